l4_arb_mux: RTL and testbench
=============================

L4_ARB_MUX -- requirements
Module: l4_arb_mux

Interface
REQ-001 Parameter NBITS, default 8: data width per channel, range 1..64.
REQ-002 Parameter NCH, default 4: number of input channels, range 2..16; SW = $clog2(NCH).
REQ-003 clk  input  1  single clock; all logic samples on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  NCH  per-channel data valid.
REQ-006 in_ready  output  NCH  per-channel accept; combinational.
REQ-007 in_data  input  NCH*NBITS  channel i occupies bits [i*NBITS +: NBITS].
REQ-008 in_last  input  NCH  per-channel end-of-packet marker.
REQ-009 out_valid  output  1  registered output valid.
REQ-010 out_ready  input  1  downstream accept.
REQ-011 out_data  output  NBITS  registered selected data.
REQ-012 out_last  output  1  registered copy of the accepted in_last.
REQ-013 out_sel  output  SW  registered index of the channel that supplied out_data.

Function
REQ-014 Transfer rules: an input transfer occurs when in_valid[i] && in_ready[i]; an output transfer occurs when out_valid && out_ready.
REQ-015 load_en = !out_valid || out_ready.
REQ-016 At most one in_ready bit is high per cycle: in_ready[i] = load_en && grant[i].
REQ-017 Round-robin grant order: search starts at pointer rr_ptr and wraps NCH-1 -> 0; grant goes to the first channel with in_valid high.
REQ-018 If no channel is valid, grant = 0.
REQ-019 On an input transfer from channel g:
  - rr_ptr <= (g+1) mod NCH;
  - out_data, out_last and out_sel load channel g's data, last and index;
  - out_valid <= 1.
REQ-020 If load_en is high and no input transfer occurs, out_valid <= 0 and all other output registers hold.
REQ-021 While out_valid && !out_ready, out_data, out_last and out_sel hold stable.
REQ-022 Latency is one cycle from input transfer to out_valid. Sustained throughput is one beat per clock when out_ready stays high.
REQ-023 in_valid[i] deasserting without a transfer is legal. The arbiter re-evaluates every cycle and retains no grant for that channel, except under REQ-027.
REQ-024 Simultaneous output and input transfer in the same cycle replaces the register contents with no bubble.

Reset
REQ-025 When rst_n is low at a clock edge, the following clear to 0 regardless of the other inputs: out_valid, out_data, out_last, out_sel, rr_ptr and the lock state.
REQ-026 in_ready is all-zero while rst_n is low. Data held in the output register when reset is asserted mid-operation is discarded.

Configuration
REQ-027 Macro L4_ARB_MUX_LOCK_EN defined (packet lock enabled):
  - a transfer with in_last=0 from channel g sets lock on g;
  - while locked, grant is onehot(g) if in_valid[g], else 0; other channels stall;
  - a transfer from g with in_last=1 clears lock and advances rr_ptr to g+1.
REQ-028 Macro L4_ARB_MUX_LOCK_EN undefined:
  - no lock state exists;
  - arbitration is per beat;
  - in_last is only passed through to out_last.

Structure
REQ-029 Shared package l4_pkg holds:
  - default-value constants L4_NBITS_DEF=8 and L4_NCH_DEF=4;
  - a clog2 width function used for SW.
REQ-030 Round-robin grant logic is one combinational sub-module, l4_rr_arbiter.
  - Inputs: req[NCH], ptr[SW], lock_en, lock_idx.
  - Output: grant[NCH], one-hot or zero.
  - l4_arb_mux instantiates it once.

Verification
REQ-031 Reset, then NCH=4, NBITS=8, all in_valid=1, data 8'hA0..8'hA3, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles; out_data A0,A1,A2,A3,A0.
REQ-032 Only channel 2 valid with data 8'h5C, out_ready=0 for 3 cycles -> out_valid=1 and out_data=8'h5C held stable; in_ready=0000 until out_ready=1, then in_ready[2] for one cycle.
REQ-033 Channels 1 and 3 valid, rr_ptr=2 -> channel 3 granted first, then channel 1.
REQ-034 Assert rst_n=0 mid-stream with out_valid=1 -> next cycle out_valid=0, out_sel=0, and the first post-reset grant goes to the lowest valid channel.
REQ-035 With L4_ARB_MUX_LOCK_EN, channel 0 sends a 3-beat packet (last on beat 3) while channel 1 is valid throughout -> out_sel 0,0,0,1; channel 1 is not granted between beats.
REQ-036 Without L4_ARB_MUX_LOCK_EN, same stimulus as REQ-035 -> out_sel 0,1,0,1,0.

Source files
------------

// File: rtl/l4_arb_mux_pkg.sv
// Shared definitions for the l4 arbitrating multiplexer: default sizes and
// the width helper used to size channel indices.
package l4_pkg;

  localparam int L4_NBITS_DEF = 8;
  localparam int L4_NCH_DEF   = 4;

  // Number of bits needed to index n items (minimum 1).
  function automatic int l4_clog2(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << k) < n) w = k + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/l4_rr_arbiter.sv
// Combinational round-robin arbiter. Searches upward from ptr, wrapping
// NCH-1 -> 0, and grants the first requester. When lock_en is set only
// lock_idx may be granted. Output is one-hot or all-zero.
module l4_rr_arbiter
  import l4_pkg::*;
#(
  parameter int NCH = L4_NCH_DEF,
  parameter int SW  = l4_clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  input  logic           lock_en,
  input  logic [SW-1:0]  lock_idx,
  output logic [NCH-1:0] grant
);

  logic [SW-1:0] idx;
  logic          found;

  // Rotating priority search, or pinned grant while a packet is locked.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (lock_en) begin
      if (req[lock_idx]) grant[lock_idx] = 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        idx = SW'((int'(ptr) + i) % NCH);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/l4_arb_mux.sv
// Round-robin N:1 stream multiplexer with a one-deep registered output.
// Handshake: a beat moves on a port in any cycle where its valid and ready
// are both high; in_ready is combinational and at most one bit is high.
// Optional feature: define L4_ARB_MUX_LOCK_EN to hold the grant on one
// channel from its first beat until the beat carrying in_last.
module l4_arb_mux
  import l4_pkg::*;
#(
  parameter int NBITS = L4_NBITS_DEF,
  parameter int NCH   = L4_NCH_DEF,
  localparam int SW   = l4_clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*NBITS-1:0] in_data,
  input  logic [NCH-1:0]       in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NBITS-1:0]     out_data,
  output logic                 out_last,
  output logic [SW-1:0]        out_sel
);

  logic             out_valid_q, out_valid_d;
  logic [NBITS-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SW-1:0]    out_sel_q, out_sel_d;
  logic [SW-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NCH-1:0]   grant;
  logic [SW-1:0]    g_idx;
  logic             load_en;
  logic             xfer;
  logic             arb_lock;
  logic [SW-1:0]    arb_lock_idx;

`ifdef L4_ARB_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic [SW-1:0]    lock_idx_q, lock_idx_d;
  assign arb_lock     = lock_q;
  assign arb_lock_idx = lock_idx_q;
`else
  assign arb_lock     = 1'b0;
  assign arb_lock_idx = '0;
`endif

  l4_rr_arbiter #(.NCH(NCH), .SW(SW)) u_arb (
    .req      (in_valid),
    .ptr      (rr_ptr_q),
    .lock_en  (arb_lock),
    .lock_idx (arb_lock_idx),
    .grant    (grant)
  );

  assign load_en = !out_valid_q || out_ready;
  assign in_ready = (rst_n && load_en) ? grant : '0;
  assign xfer     = |in_ready;

  // One-hot grant to channel index.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) g_idx = SW'(i);
    end
  end

  // Next state of the output stage, round-robin pointer and lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef L4_ARB_MUX_LOCK_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
`endif
    if (load_en) begin
      if (xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data[int'(g_idx)*NBITS +: NBITS];
        out_last_d  = in_last[g_idx];
        out_sel_d   = g_idx;
        rr_ptr_d    = (g_idx == SW'(NCH-1)) ? '0 : g_idx + 1'b1;
`ifdef L4_ARB_MUX_LOCK_EN
        lock_d      = !in_last[g_idx];
        lock_idx_d  = g_idx;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
`ifdef L4_ARB_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef L4_ARB_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_l4_arb_mux.sv
// Bench for l4_arb_mux (NCH=4, NBITS=8). Works in both builds; the
// packet-lock directed case follows L4_ARB_MUX_LOCK_EN.
module tb_l4_arb_mux;

  localparam int NCH   = 4;
  localparam int NBITS = 8;
  localparam int SW    = 2;
  localparam int W     = 1 + SW + NBITS;

  logic                 clk;
  logic                 rst_n;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [NCH*NBITS-1:0] in_data;
  logic [NCH-1:0]       in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [NBITS-1:0]     out_data;
  logic                 out_last;
  logic [SW-1:0]        out_sel;

  l4_arb_mux #(.NBITS(NBITS), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: behavioural view of the output register and arbiter.
  bit             m_valid;
  int             m_data;
  bit             m_last;
  int             m_sel;
  int             m_ptr;
  bit             m_lock;
  int             m_lock_idx;
  logic [W-1:0]   exp_q[$];

  function automatic int model_grant(input logic [NCH-1:0] v);
    int c;
    if (m_lock) return v[m_lock_idx] ? m_lock_idx : -1;
    for (int k = 0; k < NCH; k++) begin
      c = (m_ptr + k) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_last = 0; m_sel = 0;
    m_ptr = 0; m_lock = 0; m_lock_idx = 0;
    exp_q.delete();
  endtask

  // Driver: inputs are already set (just after a falling edge). Checks the
  // combinational ready, clocks once, updates the model, checks outputs.
  task automatic step();
    int           g;
    bit           le;
    logic [NCH-1:0] er;
    logic [W-1:0] e;
    #1;
    le = !m_valid || out_ready;
    g  = model_grant(in_valid);
    er = '0;
    if (rst_n && le && g >= 0) er[g] = 1'b1;
    check("in_ready", 64'(in_ready), 64'(er));
    if (rst_n && m_valid && out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stream_beat", 64'({out_last, out_sel, out_data}), 64'(e));
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (le) begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = int'(in_data[g*NBITS +: NBITS]);
        m_last  = in_last[g];
        m_sel   = g;
        m_ptr   = (g + 1) % NCH;
`ifdef L4_ARB_MUX_LOCK_EN
        m_lock     = !in_last[g];
        m_lock_idx = g;
`endif
        exp_q.push_back({in_last[g], SW'(g), NBITS'(m_data)});
      end else begin
        m_valid = 0;
      end
    end
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data", 64'(out_data), 64'(m_data));
    check("out_sel", 64'(out_sel), 64'(m_sel));
    check("out_last", 64'(out_last), 64'(m_last));
  endtask

  task automatic set_data(input int base);
    for (int c = 0; c < NCH; c++) in_data[c*NBITS +: NBITS] = NBITS'(base + c);
  endtask

  int seq_len;
  int beats_left;
  int exp_seq[5];

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset with noisy inputs: ready must stay low, outputs clear.
    in_valid = 4'hF; out_ready = 1'b1; set_data(8'h11);
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'(0));

    // Round robin with all channels valid.
    rst_n = 1'b1; in_valid = 4'hF; in_last = 4'hF; set_data(8'hA0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_seq_sel", 64'(out_sel), 64'(k % NCH));
      check("rr_seq_data", 64'(out_data), 64'(8'hA0 + (k % NCH)));
    end

    // Backpressure: single channel, output stalled, data held.
    in_valid = '0; step();
    in_valid = 4'b0100; in_data = '0; in_data[2*NBITS +: NBITS] = 8'h5C; out_ready = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_data", 64'(out_data), 64'(8'h5C));
      check("bp_hold_valid", 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 64'(in_ready), 64'(4'b0100));
    step();
    in_valid = '0; step();

    // Pointer at 2 (after a channel-1 beat): channel 3 before channel 1.
    in_valid = 4'b0010; set_data(8'h30); step();
    in_valid = 4'b1010;
    step(); check("ptr2_first", 64'(out_sel), 64'(3));
    step(); check("ptr2_second", 64'(out_sel), 64'(1));

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      in_valid  = NCH'($urandom_range(0, 15));
      in_last   = NCH'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    // Reset mid-stream with a beat held in the output register.
    in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b0; step(); step();
    check("midrst_pre_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0; step();
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_sel", 64'(out_sel), 64'(0));
    rst_n = 1'b1; in_valid = 4'b1010; out_ready = 1'b1; set_data(8'h70);
    step(); check("midrst_first_grant", 64'(out_sel), 64'(1));

    // Packet from channel 0 (3 beats) competing with channel 1.
    rst_n = 1'b0; in_valid = '0; step();
    rst_n = 1'b1;
`ifdef L4_ARB_MUX_LOCK_EN
    seq_len = 4; exp_seq = '{0, 0, 0, 1, 0};
`else
    seq_len = 5; exp_seq = '{0, 1, 0, 1, 0};
`endif
    beats_left = 3;
    for (int k = 0; k < seq_len; k++) begin
      in_valid = {2'b00, 1'b1, beats_left > 0};
      in_last  = {2'b00, 1'b1, beats_left == 1};
      set_data(8'hC0 + 4 * k);
      #1;
      if (in_ready[0]) beats_left--;
      step();
      check("pkt_seq_sel", 64'(out_sel), 64'(exp_seq[k]));
    end
    in_valid = '0; step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
